// File: rtl/core_pkg.sv
// Shared execute-stage types for the iterative multiplier.
// State encoding and counter-width helper.
package core_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Bits needed to count from 0 up to n inclusive.
  function automatic int mul_count_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int MUL_COUNT_W = mul_count_w(32);

endpackage

// File: rtl/adder.sv
// Plain ripple/inferred adder reused by the multiplier accumulate path.
// Width wraps modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add multiplier, signed/unsigned, valid/ready on both sides.
// Optional MUL_EARLY_EXIT_EN stops as soon as the remaining multiplier is zero.
module shift_add_multiplier
  import core_pkg::*;
#(
  parameter int num_bits = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [num_bits-1:0]   a,
  input  logic [num_bits-1:0]   b,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*num_bits-1:0] product
);

  localparam int PW = 2 * num_bits;
  localparam int CW = mul_count_w(num_bits);
  localparam logic [CW-1:0] LAST = CW'(num_bits);

  mul_state_t state_q, state_d;

  logic [PW-1:0]       mcand_q;
  logic [PW-1:0]       acc_q;
  logic [PW-1:0]       product_q;
  logic [num_bits-1:0] mplier_q;
  logic [CW-1:0]       count_q;
  logic                neg_q;

  logic                a_neg, b_neg;
  logic [num_bits-1:0] a_mag, b_mag;
  logic [PW-1:0]       sum_w, acc_next;
  logic [CW-1:0]       count_next;
  logic                exit_w;

  // Operand magnitudes; the most-negative value maps to 2^(n-1) unsigned.
  assign a_neg = signed_mode & a[num_bits-1];
  assign b_neg = signed_mode & b[num_bits-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  adder #(
    .WIDTH(PW)
  ) u_acc_add (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (sum_w)
  );

  assign acc_next   = mplier_q[0] ? sum_w : acc_q;
  assign count_next = count_q + 1'b1;

`ifdef MUL_EARLY_EXIT_EN
  assign exit_w = (count_next == LAST) ||
                  (mplier_q[num_bits-1:1] == '0);
`else
  assign exit_w = (count_next == LAST);
`endif

  assign product = product_q;

  // Next state and handshake flags decoded from the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL_RUN;
      end
      MUL_RUN: begin
        if (exit_w) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // State register plus load / iterate / sign-fix datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MUL_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        MUL_IDLE: begin
          if (in_valid) begin
            mcand_q  <= {{num_bits{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= signed_mode &
                        (a[num_bits-1] ^ b[num_bits-1]);
            acc_q    <= '0;
            count_q  <= '0;
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_next;
          if (exit_w) begin
            product_q <= neg_q ? (~acc_next + 1'b1) : acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed table at 8 bits plus random ops at 8/16/32.
// Expected products come from plain integer arithmetic in the bench.
module tb_shift_add_multiplier;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rdone = 0;

  logic        rst, rrst;
  logic        iv, ir, sm, ov, ordy;
  logic [7:0]  a8, b8;
  logic [15:0] p16;

  shift_add_multiplier #(.num_bits(8)) dut (
    .clk         (clk),
    .reset       (rst),
    .in_valid    (iv),
    .in_ready    (ir),
    .a           (a8),
    .b           (b8),
    .signed_mode (sm),
    .out_valid   (ov),
    .out_ready   (ordy),
    .product     (p16)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Edges from accept to out_valid for an 8-bit operation.
  function automatic int elat8(input logic [7:0] bb, input logic s);
    logic [7:0] mb;
    int bl;
    mb = (s && bb[7]) ? -bb : bb;
    bl = 0;
    for (int k = 0; k < 8; k++) if (mb[k]) bl = k + 1;
    if (!EARLY) return 8;
    return (bl == 0) ? 1 : bl;
  endfunction

  task automatic wait_ready(input string nm);
    int c = 0;
    while (!ir && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (!ir) chk({nm, " ready timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string nm, output int lat);
    lat = 0;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!ov) chk({nm, " valid timeout"}, 0, 1);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     input logic ts, input logic [15:0] texp,
                     input int tstall, input string nm);
    int lat;
    wait_ready(nm);
    a8 = ta; b8 = tb; sm = ts; iv = 1'b1;
    @(negedge clk);
    chk({nm, " accept"}, ir, 0);
    iv = 1'b0;
    wait_valid(nm, lat);
    chk({nm, " latency"}, lat, elat8(tb, ts));
    chk({nm, " product"}, p16, texp);
    for (int i = 0; i < tstall; i++) begin
      @(negedge clk);
      chk({nm, " hold"}, {ov, p16}, {1'b1, texp});
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk({nm, " post hs"}, {ov, ir, p16}, {2'b01, texp});
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int lat;
    tbl[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
    tbl[1] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
    tbl[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    tbl[3] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    tbl[4] = '{8'd0,   8'd200, 1'b0, 16'h0000};
    tbl[5] = '{8'd7,   8'd3,   1'b0, 16'h0015};
    tbl[6] = '{8'd5,   8'd0,   1'b0, 16'h0000};
    tbl[7] = '{8'h05,  8'hFF,  1'b1, 16'hFFFB};
    tbl[8] = '{8'h80,  8'h7F,  1'b1, 16'hC080};

    rst = 1'b1; rrst = 1'b1;
    iv = 1'b0; a8 = '0; b8 = '0; sm = 1'b0; ordy = 1'b0;
    @(negedge clk);
    chk("reset state", {ov, ir, p16}, {2'b01, 16'h0});
    iv = 1'b1;
    @(negedge clk);
    chk("valid in reset", {ov, ir}, 2'b01);
    iv = 1'b0;
    rst = 1'b0; rrst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      op8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p,
          i % 3, $sformatf("vec%0d", i));

    // Backpressure with a second request held during RUN and DONE.
    wait_ready("bp");
    a8 = 8'd6; b8 = 8'd7; sm = 1'b0; iv = 1'b1;
    @(negedge clk);
    chk("bp accept", ir, 0);
    a8 = 8'd3; b8 = 8'd4;
    wait_valid("bp", lat);
    chk("bp latency", lat, elat8(8'd7, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold", {ov, ir, p16}, {2'b10, 16'h002A});
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("bp hs", {ov, ir, p16}, {2'b01, 16'h002A});
    @(negedge clk);
    chk("bp second accept", ir, 0);
    iv = 1'b0;
    wait_valid("bp2", lat);
    chk("bp2 latency", lat, elat8(8'd4, 1'b0));
    chk("bp2 product", p16, 16'h000C);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("bp2 hs", {ov, ir}, 2'b01);

    // Asynchronous reset in the middle of RUN.
    a8 = 8'd100; b8 = 8'd100; sm = 1'b0; iv = 1'b1;
    @(negedge clk);
    chk("rst accept", ir, 0);
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst async", {ov, ir, p16}, {2'b01, 16'h0});
    @(negedge clk);
    rst = 1'b0;
    chk("rst held", {ov, ir, p16}, {2'b01, 16'h0});
    op8(8'd9, 8'd9, 1'b0, 16'h0051, 1, "after rst");

    for (int c = 0; c < 80000 && rdone < 3; c++) @(negedge clk);
    chk("random done", rdone, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int W    = (gi == 0) ? 8 : ((gi == 1) ? 16 : 32);
    localparam int NOPS = (gi == 0) ? 1500 : ((gi == 1) ? 600 : 300);

    logic           gv, gir, gs, gov, gor;
    logic [W-1:0]   ga, gb;
    logic [2*W-1:0] gp;

    shift_add_multiplier #(.num_bits(W)) u_dut (
      .clk         (clk),
      .reset       (rrst),
      .in_valid    (gv),
      .in_ready    (gir),
      .a           (ga),
      .b           (gb),
      .signed_mode (gs),
      .out_valid   (gov),
      .out_ready   (gor),
      .product     (gp)
    );

    initial begin
      logic [2*W-1:0] xa, xb, exp;
      logic [W-1:0]   mb;
      int bl, el, lat;
      string nm;
      gv = 1'b0; gs = 1'b0; ga = '0; gb = '0; gor = 1'b0;
      nm = $sformatf("rand%0d", W);
      wait (rrst === 1'b0);
      @(negedge clk);
      for (int n = 0; n < NOPS; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ga = W'($urandom);
        gb = W'($urandom);
        if ($urandom_range(0, 3) == 0) gb = gb >> $urandom_range(0, W - 1);
        gs = 1'($urandom_range(0, 1));
        if (gs) begin
          xa = {{W{ga[W-1]}}, ga};
          xb = {{W{gb[W-1]}}, gb};
        end else begin
          xa = {{W{1'b0}}, ga};
          xb = {{W{1'b0}}, gb};
        end
        exp = xa * xb;
        mb = (gs && gb[W-1]) ? -gb : gb;
        bl = 0;
        for (int k = 0; k < W; k++) if (mb[k]) bl = k + 1;
        el = EARLY ? ((bl == 0) ? 1 : bl) : W;
        gv = 1'b1;
        @(negedge clk);
        chk({nm, " accept"}, gir, 0);
        if ($urandom_range(0, 1) == 1) begin
          ga = ~ga;
          gb = gb + 1'b1;
        end else begin
          gv = 1'b0;
        end
        lat = 0;
        while (!gov && lat < W + 6) begin
          @(negedge clk);
          lat++;
        end
        gv = 1'b0;
        chk({nm, " latency"}, lat, el);
        chk({nm, " product"}, gp, exp);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          chk({nm, " hold"}, {gov, gp}, {1'b1, exp});
        end
        gor = 1'b1;
        @(negedge clk);
        gor = 1'b0;
        chk({nm, " hs"}, {gov, gir}, 2'b01);
      end
      rdone++;
    end
  end

endmodule
